// File: rtl/errcnt_frame_sched_if.sv
// rtl/errcnt_frame_sched_if.sv - frame stream and error-counter launch bus for errcnt_frame_sched
interface errcnt_frame_sched_if #(
  parameter int N     = 204,
  parameter int CNT_W = 8
);
  logic             frame_valid;
  logic [N-1:0]     frame_data;
  logic             frame_ready;
  logic [N-1:0]     cnt_frame;
  logic             cnt_en;
  logic             cnt_busy;
  logic             cnt_done;
  logic [CNT_W-1:0] cnt_err_count;

  // master = scheduler side, slave = decoder/counter side
  modport master (
    input  frame_valid, frame_data, cnt_busy, cnt_done, cnt_err_count,
    output frame_ready, cnt_frame, cnt_en
  );

  modport slave (
    output frame_valid, frame_data, cnt_busy, cnt_done, cnt_err_count,
    input  frame_ready, cnt_frame, cnt_en
  );
endinterface

// File: rtl/errcnt_frame_sched.sv
// rtl/errcnt_frame_sched.sv - sequences decoder frames into the error-bit counter and accumulates BER stats
module errcnt_frame_sched #(
  parameter int N           = 204,
  parameter int CNT_W       = 8,
  parameter int TOT_W       = 32,
  parameter int FRM_W       = 16,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      i_eval_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [FRM_W-1:0]          i_target_frames,
  errcnt_frame_sched_if.master      bus,
  output logic [TOT_W-1:0]          o_total_err_bits,
  output logic [FRM_W-1:0]          o_frame_err_cnt,
  output logic [FRM_W-1:0]          o_frames_done,
  output logic                      o_run_done,
  output logic                      o_timeout_err,
  output logic                      o_idle
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_FRAME, S_LAUNCH, S_WAIT_DONE, S_ACCUM, S_FINISH
  } state_t;

  state_t             r_state, w_next;
  logic [N-1:0]       r_frame;
  logic [FRM_W-1:0]   r_target;
  logic [FRM_W-1:0]   r_frames_done;
  logic [FRM_W-1:0]   r_frame_err_cnt;
  logic [TOT_W-1:0]   r_total;
  logic [CNT_W-1:0]   r_err;
  logic [WAIT_W-1:0]  r_wait;
  logic               r_done_q;
  logic               r_timeout;

  logic               w_frame_ready, w_cnt_en, w_run_done, w_idle;
  logic               w_start_run, w_capture, w_take, w_timeout, w_accum;
  logic               w_done_rise;
  logic [WAIT_W-1:0]  w_wait_inc;
  logic [FRM_W-1:0]   w_frames_inc;
  logic [TOT_W:0]     w_total_sum;
  logic [TOT_W-1:0]   w_total_sat;

  assign w_done_rise  = bus.cnt_done & ~r_done_q;
  assign w_wait_inc   = r_wait + WAIT_W'(1);
  assign w_frames_inc = r_frames_done + FRM_W'(1);
  assign w_total_sum  = {1'b0, r_total} + (TOT_W+1)'(r_err);
  assign w_total_sat  = w_total_sum[TOT_W] ? {TOT_W{1'b1}} : w_total_sum[TOT_W-1:0];

  always_comb begin
    w_next        = r_state;
    w_frame_ready = 1'b0;
    w_cnt_en      = 1'b0;
    w_run_done    = 1'b0;
    w_idle        = 1'b0;
    w_start_run   = 1'b0;
    w_capture     = 1'b0;
    w_take        = 1'b0;
    w_timeout     = 1'b0;
    w_accum       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idle = 1'b1;
        if (i_start && !i_abort) begin
          w_start_run = 1'b1;
          w_next      = (i_target_frames == '0) ? S_FINISH : S_WAIT_FRAME;
        end
      end
      S_WAIT_FRAME: begin
        w_frame_ready = ~i_abort;
        if (bus.frame_valid && !i_abort) begin
          w_capture = 1'b1;
          w_next    = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_cnt_en = ~i_abort;
        w_next   = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // a done edge in the last allowed cycle still wins over the timeout
        if (w_done_rise) begin
          w_take = 1'b1;
          w_next = S_ACCUM;
        end else if (w_wait_inc == WAIT_W'(TIMEOUT_CYC)) begin
          w_timeout = 1'b1;
          w_next    = S_FINISH;
        end
      end
      S_ACCUM: begin
        w_accum = 1'b1;
        w_next  = (w_frames_inc == r_target) ? S_FINISH : S_WAIT_FRAME;
      end
      S_FINISH: begin
        w_run_done = ~i_abort;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (i_abort && r_state != S_IDLE) begin
      w_next    = S_IDLE;
      w_take    = 1'b0;
      w_timeout = 1'b0;
      w_accum   = 1'b0;
    end
  end

  always_ff @(posedge i_eval_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_frame         <= '0;
      r_target        <= '0;
      r_frames_done   <= '0;
      r_frame_err_cnt <= '0;
      r_total         <= '0;
      r_err           <= '0;
      r_wait          <= '0;
      r_done_q        <= 1'b0;
      r_timeout       <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_done_q <= bus.cnt_done;
      if (w_start_run) begin
        r_target        <= i_target_frames;
        r_frames_done   <= '0;
        r_frame_err_cnt <= '0;
        r_total         <= '0;
        r_timeout       <= 1'b0;
      end
      if (w_capture) r_frame <= bus.frame_data;
      if (r_state == S_LAUNCH) r_wait <= '0;
      else if (r_state == S_WAIT_DONE) r_wait <= w_wait_inc;
      if (w_take) r_err <= bus.cnt_err_count;
      if (w_timeout) r_timeout <= 1'b1;
      if (w_accum) begin
        r_total       <= w_total_sat;
        r_frames_done <= w_frames_inc;
        if (r_err != '0) r_frame_err_cnt <= r_frame_err_cnt + FRM_W'(1);
      end
    end
  end

  assign bus.frame_ready  = w_frame_ready;
  assign bus.cnt_en       = w_cnt_en;
  assign bus.cnt_frame    = r_frame;
  assign o_total_err_bits = r_total;
  assign o_frame_err_cnt  = r_frame_err_cnt;
  assign o_frames_done    = r_frames_done;
  assign o_run_done       = w_run_done;
  assign o_timeout_err    = r_timeout;
  assign o_idle           = w_idle;

endmodule

// File: tb/tb_errcnt_frame_sched.sv
// tb/tb_errcnt_frame_sched.sv - directed bench with a transaction-level statistics model for errcnt_frame_sched
module tb_errcnt_frame_sched;
  localparam int N = 204, CNT_W = 8, TOT_W = 32, FRM_W = 16, TIMEOUT_CYC = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [FRM_W-1:0] target;
  logic [TOT_W-1:0] total_err_bits;
  logic [FRM_W-1:0] frame_err_cnt, frames_done;
  logic             run_done, timeout_err, idle;

  errcnt_frame_sched_if #(.N(N), .CNT_W(CNT_W)) bus ();

  errcnt_frame_sched #(.N(N), .CNT_W(CNT_W), .TOT_W(TOT_W), .FRM_W(FRM_W),
                       .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .i_eval_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_target_frames(target), .bus(bus),
    .o_total_err_bits(total_err_bits), .o_frame_err_cnt(frame_err_cnt),
    .o_frames_done(frames_done), .o_run_done(run_done),
    .o_timeout_err(timeout_err), .o_idle(idle)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int n_en = 0, n_rd = 0, n_rdy = 0;
  bit chk_on = 1'b0;

  longint       m_total;
  int           m_ferr, m_fdone;
  bit           m_to;
  logic [N-1:0] m_frame;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_total = 0; m_ferr = 0; m_fdone = 0; m_to = 1'b0;
  endtask

  task automatic model_frame(input int err);
    m_total = m_total + err;
    if (m_total > 64'hFFFF_FFFF) m_total = 64'hFFFF_FFFF;
    if (err != 0) m_ferr++;
    m_fdone++;
  endtask

  function automatic logic [N-1:0] pat(input int k);
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = ((i * k + k) % 3) == 0;
    return p;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("total_err_bits", total_err_bits, m_total[TOT_W-1:0]);
      check("frame_err_cnt", frame_err_cnt, m_ferr[FRM_W-1:0]);
      check("frames_done", frames_done, m_fdone[FRM_W-1:0]);
      check("timeout_err", timeout_err, m_to);
      check("cnt_frame", bus.cnt_frame, m_frame);
    end
    if (bus.cnt_en) n_en++;
    if (run_done) n_rd++;
    if (bus.frame_ready) n_rdy++;
  end

  task automatic start_run(input int t);
    start = 1'b1; target = FRM_W'(t);
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
  endtask

  // present a frame after gap cycles, wait for acceptance, confirm the launch pulse
  task automatic feed(input logic [N-1:0] d, input int gap);
    bit got = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.frame_valid = 1'b1; bus.frame_data = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.frame_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    bus.frame_valid = 1'b0;
    bus.frame_data  = '0;
    if (!got) begin
      check("feed_ready_seen", 1'b0, 1'b1);
      return;
    end
    m_frame = d;
    @(negedge clk);
    check("cnt_en_launch", bus.cnt_en, 1'b1);
    @(posedge clk); #1;
  endtask

  // counter model: done after lat cycles of waiting, optionally held 2 cycles
  task automatic respond(input int err, input int lat, input bit hold2, input bit last, input bit poke);
    bus.cnt_busy = 1'b1;
    if (poke) begin start = 1'b1; target = '0; end
    for (int i = 0; i < lat; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    bus.cnt_busy = 1'b0;
    bus.cnt_done = 1'b1; bus.cnt_err_count = CNT_W'(err);
    @(posedge clk); #1;
    if (!hold2) begin bus.cnt_done = 1'b0; bus.cnt_err_count = 8'hA5; end
    @(posedge clk); #1;
    bus.cnt_done = 1'b0; bus.cnt_err_count = 8'h3C;
    model_frame(err);
    @(negedge clk);
    check("run_done_at_end", run_done, last);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got stuck want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int en0, rd0, rdy0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; target = '0;
    bus.frame_valid = 1'b0; bus.frame_data = '0; bus.cnt_busy = 1'b0;
    bus.cnt_done = 1'b0; bus.cnt_err_count = '0;
    model_clear(); m_frame = '0;
    repeat (2) @(negedge clk);
    check("rst_idle", idle, 1'b1);
    check("rst_run_done", run_done, 1'b0);
    check("rst_frame_ready", bus.frame_ready, 1'b0);
    check("rst_cnt_en", bus.cnt_en, 1'b0);
    check("rst_total", total_err_bits, 0);
    @(posedge clk); #1;
    rst = 1'b0; chk_on = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // three frames with errors 5, 0, 7; a start mid-run must be ignored
    en0 = n_en; rd0 = n_rd;
    start_run(3);
    feed(pat(1), 0); respond(5, 2, 1'b0, 1'b0, 1'b0);
    feed(pat(2), 2); respond(0, 3, 1'b0, 1'b0, 1'b1);
    feed(pat(4), 0); respond(7, 1, 1'b0, 1'b1, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    check("run3_total", total_err_bits, 12);
    check("run3_ferr", frame_err_cnt, 2);
    check("run3_fdone", frames_done, 3);
    check("run3_cnt_en_pulses", n_en - en0, 3);
    check("run3_run_done_pulses", n_rd - rd0, 1);
    check("run3_idle", idle, 1'b1);

    // done held two cycles counts once
    start_run(1);
    feed(pat(5), 0); respond(9, 0, 1'b1, 1'b1, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    check("hold2_total", total_err_bits, 9);
    check("hold2_fdone", frames_done, 1);

    // zero-frame run finishes straight away without asking for a frame
    rdy0 = n_rdy; rd0 = n_rd;
    start_run(0);
    @(negedge clk);
    check("t0_run_done", run_done, 1'b1);
    check("t0_total", total_err_bits, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t0_idle", idle, 1'b1);
    check("t0_ready_cycles", n_rdy - rdy0, 0);
    check("t0_run_done_pulses", n_rd - rd0, 1);
    @(posedge clk); #1;

    // counter never answers
    start_run(1);
    feed(pat(7), 0);
    repeat (15) begin @(posedge clk); #1; end
    @(negedge clk);
    check("to_not_yet", timeout_err, 1'b0);
    @(posedge clk); #1;
    m_to = 1'b1;
    @(negedge clk);
    check("to_run_done", run_done, 1'b1);
    check("to_fdone", frames_done, 0);
    repeat (2) begin @(posedge clk); #1; end

    // abort while waiting on the 2nd of 4 frames
    rd0 = n_rd;
    start_run(4);
    feed(pat(8), 0); respond(3, 1, 1'b0, 1'b0, 1'b0);
    feed(pat(10), 1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    check("abort_cnt_en", bus.cnt_en, 1'b0);
    check("abort_idle_same_cycle", idle, 1'b0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle_next", idle, 1'b1);
    check("abort_fdone_kept", frames_done, 1);
    check("abort_no_run_done", n_rd - rd0, 0);
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; target = 16'd2;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle", idle, 1'b1);
    @(posedge clk); #1;
    start_run(2);
    @(negedge clk);
    check("restart_cleared_fdone", frames_done, 0);
    @(posedge clk); #1;
    feed(pat(11), 0); respond(1, 1, 1'b0, 1'b0, 1'b0);
    feed(pat(13), 0); respond(2, 4, 1'b0, 1'b1, 1'b0);
    check("restart_total", total_err_bits, 3);

    // reset while a frame is offered
    start_run(3);
    feed(pat(14), 0); respond(4, 1, 1'b0, 1'b0, 1'b0);
    en0 = n_en;
    bus.frame_valid = 1'b1; bus.frame_data = pat(16);
    rst = 1'b1;
    model_clear(); m_frame = '0;
    #2;
    check("rst_mid_idle", idle, 1'b1);
    check("rst_mid_total", total_err_bits, 0);
    check("rst_mid_fdone", frames_done, 0);
    check("rst_mid_cnt_frame", bus.cnt_frame, 0);
    check("rst_mid_ready", bus.frame_ready, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; bus.frame_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_no_launch", n_en - en0, 0);
    check("rst_idle_after", idle, 1'b1);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/errcnt_frame_sched.md
Name: errcnt_frame_sched

Overview:
- Sequences hard-decision frames from the decoder into the 204-bit error-bit counter.
- Per frame: captures the frame, launches the counter with a one-cycle enable, waits for the counter's done indication, then accumulates BER statistics over a programmed number of frames.
- Sits between the decoder top and the error counter on the eval_clk domain, and reports totals to the test/BSP logic.

Parameters:
- N, 204, frame length in bits (width of frame_data/cnt_frame).
- CNT_W, 8, width of the per-frame error count from the counter.
- TOT_W, 32, width of the accumulated error-bit total.
- FRM_W, 16, width of the frame counters and target.
- TIMEOUT_CYC, 16, max eval_clk cycles to wait for counter done after launch.

Ports:
- eval_clk  in  1  sole clock; all logic is on posedge eval_clk.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a measurement run (honoured only in IDLE).
- abort  in  1  level; forces return to IDLE.
- target_frames  in  FRM_W  number of frames per run, sampled on start.
- frame_valid  in  1  decoder frame available.
- frame_data  in  N  hard-decision frame.
- frame_ready  out  1  scheduler accepts a frame this cycle.
- cnt_frame  out  N  registered frame driven to the counter.
- cnt_en  out  1  counter launch pulse.
- cnt_busy  in  1  counter busy (status only).
- cnt_done  in  1  counter done; may stay high for 2 cycles.
- cnt_err_count  in  CNT_W  per-frame error count; valid while cnt_done is high.
- total_err_bits  out  TOT_W  accumulated error bits.
- frame_err_cnt  out  FRM_W  frames with a nonzero error count.
- frames_done  out  FRM_W  frames processed in the current run.
- run_done  out  1  one-cycle pulse at end of run.
- timeout_err  out  1  sticky flag: counter failed to respond.
- idle  out  1  FSM is in IDLE.

Behaviour:
- Reset (async, rst=1) values:
  - all outputs 0, except idle=1;
  - cnt_frame=0; FSM in IDLE.
  - rst asserted mid-run aborts immediately. No run_done is generated.
- FSM states: IDLE, WAIT_FRAME, LAUNCH, WAIT_DONE, ACCUM, FINISH.
- IDLE:
  - start=1 clears total_err_bits, frame_err_cnt, frames_done and timeout_err, and latches target_frames.
  - Next state is WAIT_FRAME, or FINISH if target_frames=0.
  - start outside IDLE is ignored.
- WAIT_FRAME:
  - frame_ready=1 only in this state.
  - On frame_valid & frame_ready: cnt_frame <= frame_data; go to LAUNCH.
- LAUNCH:
  - cnt_en=1 for exactly one cycle; go to WAIT_DONE.
  - cnt_frame is held stable from capture until ACCUM completes.
- WAIT_DONE:
  - Act only on the rising edge of cnt_done (cnt_done & ~cnt_done_q), so a 2-cycle done counts once.
  - On the edge: register cnt_err_count, then go to ACCUM.
  - A wait counter starts at 0 on entry. If it reaches TIMEOUT_CYC with no edge: set timeout_err=1 and go to FINISH; frames_done is not incremented.
- ACCUM (one cycle):
  - total_err_bits += err, saturating at all-ones of TOT_W.
  - frame_err_cnt += (err != 0).
  - frames_done += 1.
  - If the new frames_done equals the latched target, go to FINISH; else go to WAIT_FRAME.
- FINISH: run_done=1 for one cycle, then go to IDLE. Statistics hold until the next start.
- abort=1 in any non-IDLE state: next state is IDLE, cnt_en=0, frame_ready=0. Statistics are retained; no run_done.
- abort has priority over every transition. A simultaneous start and abort in IDLE is treated as abort (no run begins).
- Throughput: minimum 4 cycles per frame plus the counter latency.

Test Plan:
- Run of 3 frames, counter model returns 5, 0, 7 → total_err_bits=12, frame_err_cnt=2, frames_done=3, single run_done pulse; cnt_en pulsed exactly 3 times.
- cnt_done held high for 2 cycles with err=9, target=1 → accumulated once: total_err_bits=9, frames_done=1.
- target_frames=0 with start → run_done on the 2nd cycle after start; all counters 0; frame_ready never asserted.
- Counter model never asserts done, TIMEOUT_CYC=16 → timeout_err=1 at 16 cycles after LAUNCH, run_done pulses, frames_done=0.
- abort during WAIT_DONE on the 2nd of 4 frames → idle=1 next cycle, frames_done=1 retained, no run_done. A following start clears all statistics to 0.
- rst pulse in WAIT_FRAME while frame_valid=1 → all outputs at reset values immediately, idle=1, frame not consumed.
